// File: rtl/ie_alu_arbiter.sv
// ie_alu_arbiter: shares one combinational execute-stage ALU between NUM_REQ
// requesters. Round-robin grant, operands frozen in registers for the EXEC
// cycle, result captured at the end of EXEC and returned with a one-cycle ack.

// Per-requester operand-B select. The immediate is zero-extended; there is no
// sign extension anywhere in this datapath.
module ie_alu_arbiter_lane (
  input  logic [31:0] rs2,
  input  logic [11:0] imm,
  input  logic        imm_sel,
  output logic [31:0] opb
);
  // Choose immediate or rs2 as operand B
  always_comb begin
    opb = imm_sel ? {20'h00000, imm} : rs2;
  end
endmodule

module ie_alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   req_rs1,
  input  logic [NUM_REQ*32-1:0]   req_rs2,
  input  logic [NUM_REQ*12-1:0]   req_imm,
  input  logic [NUM_REQ-1:0]      req_imm_sel,
  input  logic [NUM_REQ*4-1:0]    req_alu_op,
  input  logic [31:0]             alu_result,
  output logic [31:0]             rs1_ALU_in,
  output logic [31:0]             rs2_ALU_in,
  output logic [3:0]              alu_op_out,
  output logic                    IE_mux2_SEL,
  output logic                    IE_mux2_EN,
  output logic [NUM_REQ-1:0]      ack,
  output logic [31:0]             result,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Operands latched at grant time and held for the whole op
  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] opb;
    logic [3:0]  alu_op;
    logic        imm_sel;
  } alu_req_t;

  // Per-requester views of the flat input buses
  logic [NUM_REQ-1:0][31:0] rs1_v;
  logic [NUM_REQ-1:0][31:0] rs2_v;
  logic [NUM_REQ-1:0][11:0] imm_v;
  logic [NUM_REQ-1:0][3:0]  op_v;
  logic [NUM_REQ-1:0][31:0] opb_v;

  assign rs1_v = req_rs1;
  assign rs2_v = req_rs2;
  assign imm_v = req_imm;
  assign op_v  = req_alu_op;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    ie_alu_arbiter_lane u_lane (
      .rs2     (rs2_v[g]),
      .imm     (imm_v[g]),
      .imm_sel (req_imm_sel[g]),
      .opb     (opb_v[g])
    );
  end

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  alu_req_t            op_q, op_d;
  logic                en_q, en_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [31:0]         result_q, result_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  gnt_oh;
  logic [NUM_REQ-1:0]  arb_req;
  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;

  // One-hot of the current grant; drives ack and the RESP exclusion mask
  always_comb begin
    gnt_oh         = '0;
    gnt_oh[gnt_q]  = 1'b1;
  end

  // Candidates: everyone in IDLE; in RESP the acked requester still holds req
  // high this cycle, so it is masked out to avoid a bogus regrant
  always_comb begin
    arb_req = '0;
    case (state_q)
      S_IDLE:  arb_req = req;
      S_RESP:  arb_req = req & ~gnt_oh;
      default: arb_req = '0;
    endcase
  end

  // Round-robin search from last+1 with wrap; the loop runs from lowest to
  // highest priority so the highest-priority hit is the one left standing
  always_comb begin
    int k;
    k       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = (int'(last_q) + i) % NUM_REQ;
      if (arb_req[IDX_W'(k)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(k);
      end
    end
  end

  // Next-state and next-output logic; outputs are registered copies of these
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    en_d     = 1'b0;
    ack_d    = '0;
    result_d = result_q;
    busy_d   = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (win_vld) begin
          state_d        = S_EXEC;
          last_d         = win_idx;
          gnt_d          = win_idx;
          op_d.rs1       = rs1_v[win_idx];
          op_d.opb       = opb_v[win_idx];
          op_d.alu_op    = op_v[win_idx];
          op_d.imm_sel   = req_imm_sel[win_idx];
          en_d           = 1'b1;
          busy_d         = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        // ALU is combinational off the operand registers, so its result is
        // settled by the end of this cycle
        state_d  = S_RESP;
        result_d = alu_result;
        ack_d    = gnt_oh;
        busy_d   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any op in flight without an ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= IDX_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      op_q     <= '0;
      en_q     <= 1'b0;
      ack_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      en_q     <= en_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  assign rs1_ALU_in  = op_q.rs1;
  assign rs2_ALU_in  = op_q.opb;
  assign alu_op_out  = op_q.alu_op;
  assign IE_mux2_SEL = op_q.imm_sel;
  assign IE_mux2_EN  = en_q;
  assign ack         = ack_q;
  assign result      = result_q;
  assign busy        = busy_q;

endmodule
